// File: rtl/issue_unit_pkg.sv
// issue_unit_pkg: shared sizes, opcodes, FSM encoding and opcode-to-FU mapping for the issue stage
package issue_unit_pkg;
    localparam int WORD_SIZE    = 32;
    localparam int FU_NUM       = 4;
    localparam int FU_INDEX     = $clog2(FU_NUM);
    localparam int RB_SIZE      = 8;
    localparam int RB_INDEX     = $clog2(RB_SIZE);
    localparam int OPCODE_WIDTH = 4;
    localparam int PC_WIDTH     = 16;
    localparam int BR_FU        = 3;
    localparam int BR_OFF_W     = 8;
    localparam int FW           = FU_INDEX + 1;

    localparam logic [OPCODE_WIDTH-1:0] INST_ADD  = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUB  = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] INST_MUL  = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] INST_LD   = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] INST_ST   = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] INST_BGE  = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] INST_HALT = 4'hF;

    localparam logic [FU_INDEX:0] FU_NONE = '1;

    localparam logic [1:0] ISSUE   = 2'd0;
    localparam logic [1:0] BR_WAIT = 2'd1;
    localparam logic [1:0] HALTED  = 2'd2;

    // Undefined opcodes fall through to FU_NONE, which the decoder treats as HALT
    function automatic logic [FU_INDEX:0] op_to_fu(input logic [OPCODE_WIDTH-1:0] op);
        return (op == INST_ADD || op == INST_SUB) ? FW'(0) :
               (op == INST_MUL)                   ? FW'(1) :
               (op == INST_LD  || op == INST_ST)  ? FW'(2) :
               (op == INST_BGE)                   ? FW'(BR_FU) : FU_NONE;
    endfunction
endpackage

// File: rtl/issue_unit_if.sv
// issue_unit_if: issue bus to the reservation stations plus ROB and branch-result handshakes
interface issue_unit_if;
    import issue_unit_pkg::*;
    logic [FU_INDEX:0]     fu;
    logic [RB_INDEX-1:0]   RB_index;
    logic [WORD_SIZE-1:0]  inst;
    logic                  rb_alloc;
    logic [FU_NUM-1:0]     busy_in;
    logic                  rb_full;
    logic [RB_INDEX-1:0]   rb_tail;
    logic                  br_valid;
    logic [RB_INDEX-1:0]   br_rb_index;
    logic                  br_result;
    modport master (output fu, RB_index, inst, rb_alloc,
                    input  busy_in, rb_full, rb_tail, br_valid, br_rb_index, br_result);
    modport slave  (input  fu, RB_index, inst, rb_alloc,
                    output busy_in, rb_full, rb_tail, br_valid, br_rb_index, br_result);
endinterface

// File: rtl/issue_unit_decode.sv
// issue_decode: combinational opcode decode to target FU, branch and halt flags
module issue_decode
    import issue_unit_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [FU_INDEX:0]       target,
    output logic                    is_branch,
    output logic                    is_halt
);
    always_comb begin
        target    = op_to_fu(opcode);
        is_branch = target == FW'(BR_FU);
        is_halt   = target == FU_NONE;
    end
endmodule

// File: rtl/issue_unit.sv
// issue_unit: in-order issue FSM that allocates ROB entries and stalls on branches until resolved
module issue_unit
    import issue_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    output logic [PC_WIDTH-1:0]  pc_out,
    input  logic [WORD_SIZE-1:0] inst_in,
    output logic                 halted,
    issue_unit_if.master         bus
);
    logic [1:0]             state;
    logic [FU_INDEX:0]      last_fu;
    logic [FU_INDEX:0]      target;
    logic                   is_branch;
    logic                   is_halt;
    logic [PC_WIDTH-1:0]    br_pc;
    logic [RB_INDEX-1:0]    br_tag;
    logic [BR_OFF_W-1:0]    br_off;
    logic                   stall;
    logic                   br_hit;
    logic [PC_WIDTH-1:0]    br_dest;

    issue_decode u_decode (
        .opcode    (inst_in[WORD_SIZE-1 -: OPCODE_WIDTH]),
        .target    (target),
        .is_branch (is_branch),
        .is_halt   (is_halt)
    );

    // target==last_fu covers the cycle before the station's busy flag reflects our issue
    always_comb begin
        stall   = bus.busy_in[target[FU_INDEX-1:0]] || bus.rb_full || target == last_fu;
        br_hit  = bus.br_valid && bus.br_rb_index == br_tag;
        br_dest = bus.br_result ? br_pc + {{(PC_WIDTH-BR_OFF_W){br_off[BR_OFF_W-1]}}, br_off}
                                : br_pc + PC_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ISSUE;
            pc_out       <= '0;
            halted       <= 1'b0;
            last_fu      <= FU_NONE;
            br_pc        <= '0;
            br_tag       <= '0;
            br_off       <= '0;
            bus.fu       <= FU_NONE;
            bus.RB_index <= '0;
            bus.inst     <= '0;
            bus.rb_alloc <= 1'b0;
        end else begin
            bus.fu       <= FU_NONE;
            bus.rb_alloc <= 1'b0;
            last_fu      <= FU_NONE;
            if (state == ISSUE) begin
                if (is_halt) begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end else if (!stall) begin
                    bus.fu       <= target;
                    bus.RB_index <= bus.rb_tail;
                    bus.inst     <= inst_in;
                    bus.rb_alloc <= 1'b1;
                    last_fu      <= target;
                    if (is_branch) begin
                        br_pc  <= pc_out;
                        br_tag <= bus.rb_tail;
                        br_off <= inst_in[BR_OFF_W-1:0];
                        state  <= BR_WAIT;
                    end else begin
                        pc_out <= pc_out + PC_WIDTH'(1);
                    end
                end
            end else if (state == BR_WAIT && br_hit) begin
                pc_out <= br_dest;
                state  <= ISSUE;
            end
        end
    end
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: table-driven directed checks of issue_unit plus hand-written reset corner sequences
module tb_issue_unit;
    import issue_unit_pkg::*;

    typedef struct {
        logic [3:0]  busy;
        logic        full;
        logic [2:0]  tail;
        logic        bv;
        logic [2:0]  btag;
        logic        bres;
        logic [2:0]  efu;
        logic [2:0]  erb;
        logic [15:0] epc;
        logic        ealloc;
        logic        ehalt;
        logic [31:0] einst;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [PC_WIDTH-1:0]  pc_out;
    logic [WORD_SIZE-1:0] inst_in;
    logic                 halted;
    logic [31:0]          imem [0:15];
    int                   total = 0;
    int                   passed = 0;
    vec_t                 vec [23];

    issue_unit_if bus();

    issue_unit dut (
        .clk     (clk),
        .reset   (reset),
        .pc_out  (pc_out),
        .inst_in (inst_in),
        .halted  (halted),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    assign inst_in = imem[pc_out[3:0]];

    function automatic vec_t v(input int busy, full, tail, bv, btag, bres,
                               input int efu, erb, epc, ealloc, ehalt, input logic [31:0] einst);
        vec_t r;
        r.busy = 4'(busy); r.full = 1'(full); r.tail = 3'(tail);
        r.bv = 1'(bv); r.btag = 3'(btag); r.bres = 1'(bres);
        r.efu = 3'(efu); r.erb = 3'(erb); r.epc = 16'(epc);
        r.ealloc = 1'(ealloc); r.ehalt = 1'(ehalt); r.einst = einst;
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    task automatic chk_reset(input string n);
        chk({n, " pc"}, 32'(pc_out), 32'd0);
        chk({n, " fu"}, 32'(bus.fu), 32'd7);
        chk({n, " rb"}, 32'(bus.RB_index), 32'd0);
        chk({n, " inst"}, bus.inst, 32'd0);
        chk({n, " alloc"}, 32'(bus.rb_alloc), 32'd0);
        chk({n, " halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = 32'hF000_0000;
        imem[0] = 32'h1000_0010;
        imem[1] = 32'h3000_0011;
        imem[2] = 32'h4000_0012;
        imem[3] = 32'h1000_0013;
        imem[4] = 32'h2000_0014;
        imem[5] = 32'h6000_00FD;
        imem[6] = 32'h5000_0016;
        imem[7] = 32'hF000_0000;
        vec[0]  = v(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 32'h1000_0010);
        vec[1]  = v(0, 0, 1, 0, 0, 0,  1, 1, 2, 1, 0, 32'h3000_0011);
        vec[2]  = v(0, 0, 2, 0, 0, 0,  2, 2, 3, 1, 0, 32'h4000_0012);
        vec[3]  = v(0, 0, 5, 0, 0, 0,  0, 5, 4, 1, 0, 32'h1000_0013);
        vec[4]  = v(0, 0, 6, 0, 0, 0,  7, 5, 4, 0, 0, 32'h0);
        vec[5]  = v(0, 0, 6, 0, 0, 0,  0, 6, 5, 1, 0, 32'h2000_0014);
        vec[6]  = v(0, 1, 4, 0, 0, 0,  7, 6, 5, 0, 0, 32'h0);
        vec[7]  = v(0, 1, 4, 0, 0, 0,  7, 6, 5, 0, 0, 32'h0);
        vec[8]  = v(0, 1, 4, 0, 0, 0,  7, 6, 5, 0, 0, 32'h0);
        vec[9]  = v(0, 1, 4, 0, 0, 0,  7, 6, 5, 0, 0, 32'h0);
        vec[10] = v(1, 0, 4, 0, 0, 0,  3, 4, 5, 1, 0, 32'h6000_00FD);
        vec[11] = v(0, 0, 5, 1, 2, 1,  7, 4, 5, 0, 0, 32'h0);
        vec[12] = v(0, 0, 5, 1, 4, 1,  7, 4, 2, 0, 0, 32'h0);
        vec[13] = v(0, 0, 5, 0, 0, 0,  2, 5, 3, 1, 0, 32'h4000_0012);
        vec[14] = v(0, 0, 6, 0, 0, 0,  0, 6, 4, 1, 0, 32'h1000_0013);
        vec[15] = v(0, 0, 7, 0, 0, 0,  7, 6, 4, 0, 0, 32'h0);
        vec[16] = v(0, 0, 7, 0, 0, 0,  0, 7, 5, 1, 0, 32'h2000_0014);
        vec[17] = v(0, 0, 0, 0, 0, 0,  3, 0, 5, 1, 0, 32'h6000_00FD);
        vec[18] = v(0, 0, 1, 1, 0, 0,  7, 0, 6, 0, 0, 32'h0);
        vec[19] = v(4, 0, 1, 0, 0, 0,  7, 0, 6, 0, 0, 32'h0);
        vec[20] = v(0, 0, 1, 0, 0, 0,  2, 1, 7, 1, 0, 32'h5000_0016);
        vec[21] = v(0, 0, 2, 0, 0, 0,  7, 1, 7, 0, 1, 32'h0);
        vec[22] = v(0, 0, 2, 1, 1, 1,  7, 1, 7, 0, 1, 32'h0);

        reset = 1'b1;
        bus.busy_in = '0; bus.rb_full = 1'b0; bus.rb_tail = '0;
        bus.br_valid = 1'b0; bus.br_rb_index = '0; bus.br_result = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset("reset");

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            reset = 1'b0;
            bus.busy_in = vec[i].busy; bus.rb_full = vec[i].full; bus.rb_tail = vec[i].tail;
            bus.br_valid = vec[i].bv; bus.br_rb_index = vec[i].btag; bus.br_result = vec[i].bres;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d fu", i), 32'(bus.fu), 32'(vec[i].efu));
            chk($sformatf("row%0d rb", i), 32'(bus.RB_index), 32'(vec[i].erb));
            chk($sformatf("row%0d pc", i), 32'(pc_out), 32'(vec[i].epc));
            chk($sformatf("row%0d alloc", i), 32'(bus.rb_alloc), 32'(vec[i].ealloc));
            chk($sformatf("row%0d halted", i), 32'(halted), 32'(vec[i].ehalt));
            if (vec[i].ealloc) chk($sformatf("row%0d inst", i), bus.inst, vec[i].einst);
        end

        // reset out of HALTED
        @(negedge clk);
        reset = 1'b1; bus.br_valid = 1'b0;
        imem[0] = 32'h6000_0002;
        bus.rb_tail = 3'd3;
        @(posedge clk);
        #1 chk_reset("rst_halted");

        // BGE at pc 0 enters BR_WAIT; reset wins over a matching taken result
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("bw_issue fu", 32'(bus.fu), 32'd3);
        chk("bw_issue rb", 32'(bus.RB_index), 32'd3);
        chk("bw_issue alloc", 32'(bus.rb_alloc), 32'd1);
        chk("bw_issue pc", 32'(pc_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.br_valid = 1'b1; bus.br_rb_index = 3'd3; bus.br_result = 1'b1;
        @(posedge clk);
        #1 chk_reset("rst_brwait");
        @(negedge clk);
        reset = 1'b0; bus.br_valid = 1'b0; bus.rb_tail = 3'd6;
        @(posedge clk);
        #1;
        chk("post_rst fu", 32'(bus.fu), 32'd3);
        chk("post_rst rb", 32'(bus.RB_index), 32'd6);
        chk("post_rst alloc", 32'(bus.rb_alloc), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
